// File: rtl/usr_pkg.sv
// Shared mode encoding for the universal shift register and its stage cells.
package usr_pkg;
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef logic [1:0] mode_t;
endpackage

// File: rtl/usr_stage.sv
// One WIDTH-bit storage stage with a hold/up/down/load next-value mux.
// Latency 1 clock; no backpressure, i_en=0 freezes the stage.
module usr_stage
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  mode_t            i_mode,
    input  logic [WIDTH-1:0] i_up_dat,
    input  logic [WIDTH-1:0] i_dn_dat,
    input  logic [WIDTH-1:0] i_ld_dat,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_next = r_q;
        case (i_mode)
            MODE_HOLD: w_next = r_q;
            MODE_UP:   w_next = i_up_dat;
            MODE_DOWN: w_next = i_dn_dat;
            MODE_LOAD: w_next = i_ld_dat;
            default:   w_next = r_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= w_next;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/universal_shift_register.sv
// DEPTH x WIDTH shift/rotate/load register bank with a saturating fill counter.
// Latency 1 clock; no backpressure, en=0 freezes all state.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [1:0]             mode,
    input  logic                   rotate,
    input  logic [WIDTH-1:0]       sin_lo,
    input  logic [WIDTH-1:0]       sin_hi,
    input  logic [WIDTH*DEPTH-1:0] pload,
    output logic [WIDTH*DEPTH-1:0] q,
    output logic [WIDTH-1:0]       sout_hi,
    output logic [WIDTH-1:0]       sout_lo,
    output logic [CW-1:0]          count,
    output logic                   full
);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [WIDTH-1:0] w_stage [DEPTH];
    logic [WIDTH-1:0] w_up    [DEPTH];
    logic [WIDTH-1:0] w_dn    [DEPTH];
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        // End stages take either the wrapped opposite end or the serial input.
        if (i == 0) begin : g_up_end
            assign w_up[i] = rotate ? w_stage[DEPTH-1] : sin_lo;
        end else begin : g_up_mid
            assign w_up[i] = w_stage[i-1];
        end

        if (i == DEPTH - 1) begin : g_dn_end
            assign w_dn[i] = rotate ? w_stage[0] : sin_hi;
        end else begin : g_dn_mid
            assign w_dn[i] = w_stage[i+1];
        end

        usr_stage #(.WIDTH(WIDTH)) u_stage (
            .i_clk    (clk),
            .i_rst    (rst),
            .i_en     (en),
            .i_mode   (mode),
            .i_up_dat (w_up[i]),
            .i_dn_dat (w_dn[i]),
            .i_ld_dat (pload[i*WIDTH +: WIDTH]),
            .o_q      (w_stage[i])
        );

        assign q[i*WIDTH +: WIDTH] = w_stage[i];
    end

    // Rotation recirculates existing data, so only serial shifts add fill.
    always_comb begin
        w_count_nxt = r_count;
        case (mode)
            MODE_LOAD: w_count_nxt = C_DEPTH;
            MODE_UP, MODE_DOWN: begin
                if (!rotate && (r_count != C_DEPTH)) begin
                    w_count_nxt = r_count + CW'(1);
                end
            end
            default:   w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= w_count_nxt;
        end
    end

    assign count   = r_count;
    assign full    = (r_count == C_DEPTH);
    assign sout_hi = w_stage[DEPTH-1];
    assign sout_lo = w_stage[0];
endmodule

// File: tb/tb_universal_shift_register.sv
// Directed and randomized checks of universal_shift_register against a packed-word reference model.
module tb_universal_shift_register;
    import usr_pkg::*;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic [1:0]       mode = MODE_HOLD;
    logic             rotate = 1'b0;
    logic [W-1:0]     sin_lo = '0;
    logic [W-1:0]     sin_hi = '0;
    logic [W*D-1:0]   pload = '0;
    logic [W*D-1:0]   q;
    logic [W-1:0]     sout_hi;
    logic [W-1:0]     sout_lo;
    logic [CW-1:0]    count;
    logic             full;

    int checks = 0;
    int errors = 0;

    // Reference: whole register as one word; UP is a left shift by a lane, DOWN a right shift.
    logic [W*D-1:0] m_q = '0;
    int             m_cnt = 0;

    always #5 clk = ~clk;

    universal_shift_register #(.WIDTH(W), .DEPTH(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .rotate  (rotate),
        .sin_lo  (sin_lo),
        .sin_hi  (sin_hi),
        .pload   (pload),
        .q       (q),
        .sout_hi (sout_hi),
        .sout_lo (sout_lo),
        .count   (count),
        .full    (full)
    );

    task automatic drive(input logic r, input logic e, input logic [1:0] m, input logic rot,
                         input logic [W-1:0] slo, input logic [W-1:0] shi, input logic [W*D-1:0] pl);
        logic [W*D-1:0] ins;
        rst = r; en = e; mode = m; rotate = rot; sin_lo = slo; sin_hi = shi; pload = pl;
        @(posedge clk);
        if (r) begin
            m_q = '0;
            m_cnt = 0;
        end else if (e) begin
            if (m == MODE_UP) begin
                ins = rot ? (m_q >> (W * (D - 1))) : {{(W*(D-1)){1'b0}}, slo};
                m_q = (m_q << W) | ins;
                if (!rot) m_cnt = (m_cnt < D) ? m_cnt + 1 : D;
            end else if (m == MODE_DOWN) begin
                ins = rot ? (m_q << (W * (D - 1))) : ({{(W*(D-1)){1'b0}}, shi} << (W * (D - 1)));
                m_q = (m_q >> W) | ins;
                if (!rot) m_cnt = (m_cnt < D) ? m_cnt + 1 : D;
            end else if (m == MODE_LOAD) begin
                m_q = pl;
                m_cnt = D;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, MODE_LOAD, 1'b0, 8'h00, 8'h00, 32'hFFFF_FFFF);
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL reset_q got %h exp %h", q, 32'h0); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (sout_hi !== 8'h00 || sout_lo !== 8'h00) begin
            errors++; $display("FAIL reset_sout got %h/%h exp 00/00", sout_hi, sout_lo);
        end
        drive(1'b0, 1'b0, MODE_HOLD, 1'b0, 8'h00, 8'h00, 32'h0);
    endtask

    task automatic test_up_fill();
        logic [W-1:0] vals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, MODE_UP, 1'b0, vals[i], 8'h00, 32'h0);
            checks++; if (count !== CW'(i + 1)) begin
                errors++; $display("FAIL up_fill_count[%0d] got %0d exp %0d", i, count, i + 1);
            end
        end
        checks++; if (q !== 32'h1122_3344) begin errors++; $display("FAIL up_fill_q got %h exp 11223344", q); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL up_fill_full got %b exp 1", full); end
        drive(1'b0, 1'b1, MODE_UP, 1'b0, vals[4], 8'h00, 32'h0);
        checks++; if (q !== 32'h2233_4455) begin errors++; $display("FAIL up_sat_q got %h exp 22334455", q); end
        checks++; if (sout_hi !== 8'h22 || sout_lo !== 8'h55) begin
            errors++; $display("FAIL up_sat_sout got %h/%h exp 22/55", sout_hi, sout_lo);
        end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL up_sat_count got %0d exp 4", count); end
    endtask

    task automatic test_rotate();
        drive(1'b0, 1'b1, MODE_LOAD, 1'b1, 8'h00, 8'h00, 32'hD4C3_B2A1);
        checks++; if (q !== 32'hD4C3_B2A1) begin errors++; $display("FAIL load_q got %h exp D4C3B2A1", q); end
        drive(1'b0, 1'b1, MODE_DOWN, 1'b1, 8'hEE, 8'hEE, 32'h0);
        checks++; if (q !== 32'hA1D4_C3B2) begin errors++; $display("FAIL rot_down_q got %h exp A1D4C3B2", q); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL rot_down_count got %0d exp 4", count); end
        drive(1'b0, 1'b1, MODE_UP, 1'b1, 8'hEE, 8'hEE, 32'h0);
        checks++; if (q !== 32'hD4C3_B2A1) begin errors++; $display("FAIL rot_up_q got %h exp D4C3B2A1", q); end
    endtask

    task automatic test_down_fill();
        drive(1'b1, 1'b0, MODE_HOLD, 1'b0, 8'h00, 8'h00, 32'h0);
        drive(1'b0, 1'b1, MODE_DOWN, 1'b0, 8'h00, 8'h7E, 32'h0);
        checks++; if (q !== 32'h7E00_0000) begin errors++; $display("FAIL down1_q got %h exp 7E000000", q); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL down1_count got %0d exp 1", count); end
        drive(1'b0, 1'b1, MODE_DOWN, 1'b0, 8'h00, 8'h7E, 32'h0);
        checks++; if (q !== 32'h7E7E_0000) begin errors++; $display("FAIL down2_q got %h exp 7E7E0000", q); end
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL down2_count got %0d exp 2", count); end
    endtask

    task automatic test_enable();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, MODE_UP, 1'b0, 8'h99, 8'h99, 32'h0);
            checks++; if (q !== 32'h7E7E_0000 || count !== 3'd2) begin
                errors++; $display("FAIL en_low[%0d] got q=%h cnt=%0d exp q=7E7E0000 cnt=2", i, q, count);
            end
        end
        drive(1'b0, 1'b1, MODE_HOLD, 1'b1, 8'h99, 8'h99, 32'hFFFF_FFFF);
        checks++; if (q !== 32'h7E7E_0000 || count !== 3'd2) begin
            errors++; $display("FAIL hold got q=%h cnt=%0d exp q=7E7E0000 cnt=2", q, count);
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 1'b0, MODE_HOLD, 1'b0, 8'h00, 8'h00, 32'h0);
        drive(1'b0, 1'b1, MODE_UP, 1'b0, 8'h11, 8'h00, 32'h0);
        drive(1'b0, 1'b1, MODE_UP, 1'b0, 8'h22, 8'h00, 32'h0);
        checks++; if (q !== 32'h0000_1122) begin errors++; $display("FAIL pre_rst_q got %h exp 00001122", q); end
        drive(1'b1, 1'b1, MODE_UP, 1'b0, 8'h33, 8'h00, 32'h0);
        checks++; if (q !== 32'h0 || count !== 3'd0) begin
            errors++; $display("FAIL mid_rst got q=%h cnt=%0d exp q=0 cnt=0", q, count);
        end
        drive(1'b0, 1'b1, MODE_UP, 1'b0, 8'h01, 8'h00, 32'h0);
        checks++; if (q !== 32'h0000_0001 || count !== 3'd1) begin
            errors++; $display("FAIL post_rst got q=%h cnt=%0d exp q=00000001 cnt=1", q, count);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 32'($urandom));
            checks++; if (q !== m_q) begin errors++; $display("FAIL rnd_q[%0d] got %h exp %h", n, q, m_q); end
            checks++; if (count !== CW'(m_cnt)) begin
                errors++; $display("FAIL rnd_count[%0d] got %0d exp %0d", n, count, m_cnt);
            end
            checks++; if (full !== (m_cnt == D)) begin
                errors++; $display("FAIL rnd_full[%0d] got %b exp %b", n, full, (m_cnt == D));
            end
            checks++; if (sout_hi !== m_q[W*D-1 -: W] || sout_lo !== m_q[W-1:0]) begin
                errors++; $display("FAIL rnd_sout[%0d] got %h/%h exp %h/%h", n, sout_hi, sout_lo,
                                   m_q[W*D-1 -: W], m_q[W-1:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_fill();
        test_rotate();
        test_down_fill();
        test_enable();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
